// File: rtl/uart_pkg.sv
// Shared register map, status/control bit positions and address decode
// for the UART FIFO controller.
package uart_pkg;

    // Register offsets from the window base
    localparam logic [31:0] OFF_RX_DATA = 32'h0000_0000;
    localparam logic [31:0] OFF_TX_DATA = 32'h0000_0004;
    localparam logic [31:0] OFF_STAT    = 32'h0000_0008;
    localparam logic [31:0] OFF_CTRL    = 32'h0000_000C;
    localparam logic [31:0] OFF_LEVEL   = 32'h0000_0010;

    // STAT bit indices
    localparam int unsigned STAT_RX_EMPTY = 0;
    localparam int unsigned STAT_RX_FULL  = 1;
    localparam int unsigned STAT_TX_EMPTY = 2;
    localparam int unsigned STAT_TX_FULL  = 3;
    localparam int unsigned STAT_OVR      = 4;
    localparam int unsigned STAT_FERR     = 5;
    localparam int unsigned STAT_TX_OVF   = 6;

    // CTRL bit indices
    localparam int unsigned CTRL_RX_IE    = 0;
    localparam int unsigned CTRL_TX_IE    = 1;
    localparam int unsigned CTRL_ERR_IE   = 2;
    localparam int unsigned CTRL_RX_FLUSH = 3;
    localparam int unsigned CTRL_TX_FLUSH = 4;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_RX_DATA,
        REG_TX_DATA,
        REG_STAT,
        REG_CTRL,
        REG_LEVEL
    } reg_sel_e;

    // Map a window-relative offset to a register select
    function automatic reg_sel_e decode_offset(input logic [31:0] off);
        case (off)
            OFF_RX_DATA: decode_offset = REG_RX_DATA;
            OFF_TX_DATA: decode_offset = REG_TX_DATA;
            OFF_STAT:    decode_offset = REG_STAT;
            OFF_CTRL:    decode_offset = REG_CTRL;
            OFF_LEVEL:   decode_offset = REG_LEVEL;
            default:     decode_offset = REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with combinational head output, synchronous flush and
// an occupancy count. Push on a full FIFO succeeds only with a same-cycle pop;
// flush overrides push and pop.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    import uart_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign count = count_q;
    assign dout  = mem_q[rd_ptr_q];

    // Pointer and count next-state, flush taking priority
    always_comb begin
        pop_ok   = pop && !empty && !flush;
        push_ok  = push && (!full || pop_ok) && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART FIFO controller: Wishbone-lite register window in front of an RX
// FIFO (filled by the deserializer) and a TX FIFO (drained by the
// serializer), with sticky error flags and a level interrupt.
module uart_fifo_ctrl #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned RX_DEPTH  = 8,
    parameter int unsigned TX_DEPTH  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wb_valid,
    input  logic [31:0]       i_wb_adr,
    input  logic              i_wb_we,
    input  logic [31:0]       i_wb_dat,
    input  logic [3:0]        i_wb_sel,
    output logic              o_wb_ack,
    output logic [31:0]       o_wb_dat,
    input  logic              i_rx_valid,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_frame_err,
    output logic              o_tx_valid,
    output logic [DATA_W-1:0] o_tx_data,
    input  logic              i_tx_ready,
    output logic              o_irq
);
    import uart_pkg::*;

    localparam int unsigned RX_CW = $clog2(RX_DEPTH) + 1;
    localparam int unsigned TX_CW = $clog2(TX_DEPTH) + 1;

    // Registered state
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        irq_q, irq_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        ovr_q, ovr_d;
    logic        ferr_q, ferr_d;
    logic        txovf_q, txovf_d;

    // FIFO interface
    logic              rx_push, rx_pop, rx_flush, rx_empty, rx_full;
    logic              tx_push, tx_pop, tx_flush, tx_empty, tx_full;
    logic [DATA_W-1:0] rx_dout, tx_dout;
    logic [RX_CW-1:0]  rx_count;
    logic [TX_CW-1:0]  tx_count;

    // Bus decode and datapath helpers
    reg_sel_e    sel;
    logic        accept, rd, wr;
    logic        rx_push_req, tx_push_req, stat_clr;
    logic [31:0] stat, level, rdata;
    logic        unused_ok;

    assign unused_ok = &{1'b0, i_wb_sel, i_wb_dat};

    // Transaction accept, FIFO control, sticky flags, read mux, irq
    always_comb begin
        sel    = decode_offset(i_wb_adr - BASE_ADDR);
        accept = i_wb_valid && !ack_q;
        rd     = accept && !i_wb_we;
        wr     = accept && i_wb_we;

        rx_pop      = rd && (sel == REG_RX_DATA) && !rx_empty;
        rx_flush    = wr && (sel == REG_CTRL) && i_wb_dat[CTRL_RX_FLUSH];
        rx_push_req = i_rx_valid && !i_frame_err;
        rx_push     = rx_push_req && (!rx_full || rx_pop);

        tx_pop      = !tx_empty && i_tx_ready;
        tx_flush    = wr && (sel == REG_CTRL) && i_wb_dat[CTRL_TX_FLUSH];
        tx_push_req = wr && (sel == REG_TX_DATA);
        tx_push     = tx_push_req && (!tx_full || tx_pop);

        // Sticky flags: a set event wins over the clear-on-read
        stat_clr = rd && (sel == REG_STAT);
        ovr_d    = (rx_push_req && rx_full && !rx_pop) || (ovr_q && !stat_clr);
        ferr_d   = (i_rx_valid && i_frame_err) || (ferr_q && !stat_clr);
        txovf_d  = (tx_push_req && tx_full && !tx_pop) || (txovf_q && !stat_clr);

        ctrl_d = ctrl_q;
        if (wr && (sel == REG_CTRL)) ctrl_d = i_wb_dat[2:0];

        stat                = '0;
        stat[STAT_RX_EMPTY] = rx_empty;
        stat[STAT_RX_FULL]  = rx_full;
        stat[STAT_TX_EMPTY] = tx_empty;
        stat[STAT_TX_FULL]  = tx_full;
        stat[STAT_OVR]      = ovr_q;
        stat[STAT_FERR]     = ferr_q;
        stat[STAT_TX_OVF]   = txovf_q;

        level = {{(16-TX_CW){1'b0}}, tx_count, {(16-RX_CW){1'b0}}, rx_count};

        case (sel)
            REG_RX_DATA: rdata = rx_empty ? '0 : {{(32-DATA_W){1'b0}}, rx_dout};
            REG_STAT:    rdata = stat;
            REG_CTRL:    rdata = {29'b0, ctrl_q};
            REG_LEVEL:   rdata = level;
            default:     rdata = '0;
        endcase

        ack_d = accept;
        dat_d = rd ? rdata : dat_q;

        irq_d = (ctrl_q[CTRL_RX_IE] && !rx_empty) ||
                (ctrl_q[CTRL_TX_IE] && tx_empty) ||
                (ctrl_q[CTRL_ERR_IE] && (ovr_q || ferr_q || txovf_q));
    end

    // Bus response, control and flag registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            dat_q   <= '0;
            irq_q   <= 1'b0;
            ctrl_q  <= '0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            txovf_q <= 1'b0;
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            irq_q   <= irq_d;
            ctrl_q  <= ctrl_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
            txovf_q <= txovf_d;
        end
    end

    assign o_wb_ack   = ack_q;
    assign o_wb_dat   = dat_q;
    assign o_irq      = irq_q;
    assign o_tx_valid = !tx_empty;
    // Gate the head so the output is 0 when nothing valid is stored
    assign o_tx_data  = tx_empty ? '0 : tx_dout;

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .pop   (rx_pop),
        .flush (rx_flush),
        .din   (i_rx_data),
        .dout  (rx_dout),
        .empty (rx_empty),
        .full  (rx_full),
        .count (rx_count)
    );

    uart_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .pop   (tx_pop),
        .flush (tx_flush),
        .din   (i_wb_dat[DATA_W-1:0]),
        .dout  (tx_dout),
        .empty (tx_empty),
        .full  (tx_full),
        .count (tx_count)
    );

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Directed bench for uart_fifo_ctrl with default parameters.
module tb_uart_fifo_ctrl;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_RX   = BASE + 32'h00;
    localparam logic [31:0] A_TX   = BASE + 32'h04;
    localparam logic [31:0] A_STAT = BASE + 32'h08;
    localparam logic [31:0] A_CTRL = BASE + 32'h0C;
    localparam logic [31:0] A_LVL  = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_wb_valid = 1'b0;
    logic [31:0] i_wb_adr = '0;
    logic        i_wb_we = 1'b0;
    logic [31:0] i_wb_dat = '0;
    logic [3:0]  i_wb_sel = 4'hF;
    logic        o_wb_ack;
    logic [31:0] o_wb_dat;
    logic        i_rx_valid = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_frame_err = 1'b0;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready = 1'b0;
    logic        o_irq;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_fifo_ctrl #(
        .DATA_W    (8),
        .RX_DEPTH  (8),
        .TX_DEPTH  (8),
        .BASE_ADDR (BASE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_wb_valid  (i_wb_valid),
        .i_wb_adr    (i_wb_adr),
        .i_wb_we     (i_wb_we),
        .i_wb_dat    (i_wb_dat),
        .i_wb_sel    (i_wb_sel),
        .o_wb_ack    (o_wb_ack),
        .o_wb_dat    (o_wb_dat),
        .i_rx_valid  (i_rx_valid),
        .i_rx_data   (i_rx_data),
        .i_frame_err (i_frame_err),
        .o_tx_valid  (o_tx_valid),
        .o_tx_data   (o_tx_data),
        .i_tx_ready  (i_tx_ready),
        .o_irq       (o_irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bus transaction; ack must appear one cycle after valid, bounded wait
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                           output logic [31:0] rdat);
        int n;
        i_wb_valid = 1'b1;
        i_wb_we    = we;
        i_wb_adr   = adr;
        i_wb_dat   = wdat;
        n = 0;
        do begin
            step();
            n++;
        end while (!o_wb_ack && n < 8);
        chk("ack_latency", n, 1);
        rdat = o_wb_dat;
        i_wb_valid = 1'b0;
        i_wb_we    = 1'b0;
        step();
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [31:0] wdat);
        logic [31:0] dummy;
        wb_xfer(1'b1, adr, wdat, dummy);
    endtask

    task automatic wb_read_chk(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] d;
        wb_xfer(1'b0, adr, 32'h0, d);
        chk(tag, d, exp);
    endtask

    task automatic rx_strobe(input logic [7:0] d, input logic ferr);
        i_rx_valid  = 1'b1;
        i_rx_data   = d;
        i_frame_err = ferr;
        step();
        i_rx_valid  = 1'b0;
        i_frame_err = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        chk("rst_ack", {31'b0, o_wb_ack}, 32'h0);
        chk("rst_dat", o_wb_dat, 32'h0);
        chk("rst_txv", {31'b0, o_tx_valid}, 32'h0);
        chk("rst_txd", {24'b0, o_tx_data}, 32'h0);
        chk("rst_irq", {31'b0, o_irq}, 32'h0);
        rst = 1'b0;
        step();
        wb_read_chk("rst_stat", A_STAT, 32'h05);

        // Basic RX order and empty read
        rx_strobe(8'h41, 1'b0);
        rx_strobe(8'h42, 1'b0);
        wb_read_chk("rx_first", A_RX, 32'h41);
        wb_read_chk("rx_second", A_RX, 32'h42);
        wb_read_chk("rx_empty_read", A_RX, 32'h0);
        wb_read_chk("rx_empty_stat", A_STAT, 32'h05);

        // RX overrun: 9 strobes into 8 entries
        for (int i = 0; i < 9; i++) rx_strobe(8'(8'h10 + i), 1'b0);
        wb_read_chk("ovr_level", A_LVL, 32'h0000_0008);
        wb_read_chk("ovr_stat", A_STAT, 32'h16);
        wb_read_chk("ovr_cleared", A_STAT, 32'h06);

        // Full RX with same-cycle strobe and RX_DATA read
        begin
            logic [31:0] d;
            i_wb_valid = 1'b1;
            i_wb_we    = 1'b0;
            i_wb_adr   = A_RX;
            i_rx_valid = 1'b1;
            i_rx_data  = 8'h18;
            step();
            i_rx_valid = 1'b0;
            chk("same_cyc_ack", {31'b0, o_wb_ack}, 32'h1);
            d = o_wb_dat;
            chk("same_cyc_data", d, 32'h10);
            i_wb_valid = 1'b0;
            step();
        end
        wb_read_chk("same_cyc_stat", A_STAT, 32'h06);
        wb_read_chk("same_cyc_level", A_LVL, 32'h0000_0008);
        for (int i = 0; i < 8; i++) wb_read_chk("drain_order", A_RX, 32'(32'h11 + i));
        wb_read_chk("drained_stat", A_STAT, 32'h05);

        // TX overflow then drain at one byte per cycle
        i_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) wb_write(A_TX, 32'(32'hA0 + i));
        wb_read_chk("txovf_stat", A_STAT, 32'h49);
        wb_read_chk("tx_level", A_LVL, 32'h0008_0000);
        i_tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("tx_valid", {31'b0, o_tx_valid}, 32'h1);
            chk("tx_data", {24'b0, o_tx_data}, 32'(32'hA0 + i));
            step();
        end
        chk("tx_done", {31'b0, o_tx_valid}, 32'h0);
        i_tx_ready = 1'b0;
        wb_read_chk("tx_drained_stat", A_STAT, 32'h05);

        // Framing error with err_ie
        wb_write(A_CTRL, 32'h04);
        rx_strobe(8'h55, 1'b1);
        step();
        chk("ferr_irq", {31'b0, o_irq}, 32'h1);
        wb_read_chk("ferr_level", A_LVL, 32'h0);
        wb_read_chk("ferr_stat", A_STAT, 32'h25);
        wb_read_chk("ctrl_rb", A_CTRL, 32'h04);
        step();
        chk("ferr_irq_clr", {31'b0, o_irq}, 32'h0);

        // Flush both FIFOs
        rx_strobe(8'h61, 1'b0);
        rx_strobe(8'h62, 1'b0);
        for (int i = 0; i < 3; i++) wb_write(A_TX, 32'(32'h70 + i));
        wb_read_chk("pre_flush_lvl", A_LVL, 32'h0003_0002);
        wb_write(A_CTRL, 32'h18);
        wb_read_chk("flush_lvl", A_LVL, 32'h0);
        wb_read_chk("flush_ctrl", A_CTRL, 32'h0);
        chk("flush_txv", {31'b0, o_tx_valid}, 32'h0);

        // tx_ie with empty TX raises irq
        wb_write(A_CTRL, 32'h02);
        step();
        chk("tx_ie_irq", {31'b0, o_irq}, 32'h1);
        wb_write(A_CTRL, 32'h00);
        step();
        chk("irq_off", {31'b0, o_irq}, 32'h0);

        // Unmapped address reads 0, write ignored
        wb_write(BASE + 32'h20, 32'hFF);
        wb_read_chk("unmapped_rd", BASE + 32'h20, 32'h0);
        wb_read_chk("unmapped_no_fx", A_CTRL, 32'h0);

        // Reset asserted mid-transaction: no ack, no push
        i_wb_valid = 1'b1;
        i_wb_we    = 1'b1;
        i_wb_adr   = A_TX;
        i_wb_dat   = 32'h99;
        rst = 1'b1;
        step();
        chk("abort_ack", {31'b0, o_wb_ack}, 32'h0);
        i_wb_valid = 1'b0;
        i_wb_we    = 1'b0;
        step();
        rst = 1'b0;
        step();
        wb_read_chk("abort_level", A_LVL, 32'h0);
        wb_read_chk("abort_stat", A_STAT, 32'h05);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_fifo_ctrl.md
UART_FIFO_CTRL -- requirements
Module: uart_fifo_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, UART character width in bits (5..16).
REQ-002 SHALL have parameter RX_DEPTH, default 8, RX FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter TX_DEPTH, default 8, TX FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter BASE_ADDR, default 32'h3000_0000, register window base.
REQ-005 SHALL have ports: clk input 1, the single clock; rst input 1, asynchronous active-high reset.
REQ-006 SHALL have Wishbone-lite slave ports: i_wb_valid in 1; i_wb_adr in 32; i_wb_we in 1; i_wb_dat in 32; i_wb_sel in 4 (ignored); o_wb_ack out 1; o_wb_dat out 32.
REQ-007 SHALL have RX-side ports: i_rx_valid in 1, one-cycle character strobe; i_rx_data in DATA_W; i_frame_err in 1, qualifies the same strobe.
REQ-008 SHALL have TX-side ports: o_tx_valid out 1; o_tx_data out DATA_W; i_tx_ready in 1, serializer accepts.
REQ-009 SHALL have o_irq out 1, the level interrupt.

Function
REQ-010 SHALL decode offsets from BASE_ADDR: 0x00 RX_DATA (R), 0x04 TX_DATA (W), 0x08 STAT (R), 0x0C CTRL (R/W), 0x10 LEVEL (R); any other address reads 0, ignores writes.
REQ-011 SHALL assert o_wb_ack one cycle after i_wb_valid rises, for exactly one cycle; a transaction is accepted only when i_wb_valid=1 and o_wb_ack=0, so side effects occur once per transaction.
REQ-012 SHALL register o_wb_dat in the same cycle as o_wb_ack, zero-extended; o_wb_dat holds its value when no read is accepted.
REQ-013 SHALL pop the RX FIFO on an accepted RX_DATA read when it is not empty and return the head; when it is empty, the read SHALL return 0 and pop nothing.
REQ-014 SHALL push i_wb_dat[DATA_W-1:0] to the TX FIFO on an accepted TX_DATA write when it is not full; when it is full, the write SHALL be dropped, set sticky TX_OVF, and still ack.
REQ-015 SHALL, on i_rx_valid with i_frame_err=1, discard the character and set sticky FERR.
REQ-016 SHALL, on i_rx_valid with i_frame_err=0, push to the RX FIFO; when RX is full and not popped in the same cycle, it SHALL drop the character and set sticky OVR.
REQ-017 SHALL let push and pop in the same cycle both succeed on a full or non-empty FIFO; the count is unchanged.
REQ-018 SHALL present the TX FIFO as first-word fall-through: o_tx_valid=!tx_empty, o_tx_data=head; a pop occurs on o_tx_valid&&i_tx_ready.
REQ-019 SHALL set STAT bits as: [0] rx_empty, [1] rx_full, [2] tx_empty, [3] tx_full, [4] OVR, [5] FERR, [6] TX_OVF, others 0.
REQ-020 SHALL clear STAT[6:4] on an accepted STAT read; a set event in the same cycle SHALL win, leaving the bit set.
REQ-021 SHALL define CTRL as: [0] rx_ie, [1] tx_ie, [2] err_ie, [3] rx_flush, [4] tx_flush; flush bits are self-clearing and read as 0.
REQ-022 SHALL empty the corresponding FIFO next cycle on a flush write; a flush overrides a same-cycle push or pop.
REQ-023 SHALL report LEVEL as [15:0] RX count and [31:16] TX count, with count width $clog2(DEPTH)+1.
REQ-024 SHALL register o_irq as (rx_ie&!rx_empty)|(tx_ie&tx_empty)|(err_ie&(OVR|FERR|TX_OVF)).

Reset
REQ-025 SHALL, on rst, clear FIFOs, counts and pointers, CTRL and sticky bits; outputs SHALL reset to o_wb_ack=0, o_wb_dat=0, o_tx_valid=0, o_tx_data=0, o_irq=0; STAT reads 0x05.
REQ-026 SHALL abort any transaction in flight when rst asserts mid-transaction, with no ack and no side effect; the master retries.

Structure
REQ-027 SHALL place register offsets, STAT and CTRL bit indices in shared package uart_pkg.
REQ-028 SHALL implement both FIFOs as instances of one sub-module uart_sync_fifo (params WIDTH, DEPTH; ports push, pop, flush, din, dout, empty, full, count).

Verification
REQ-029 SHALL be verified by: push 0x41,0x42 via i_rx_valid; read RX_DATA twice -> 0x41 then 0x42; third read -> 0, STAT[0]=1.
REQ-030 SHALL be verified by: 9 RX strobes with RX_DEPTH=8, no reads -> LEVEL[15:0]=8, STAT[4]=1; STAT read -> next STAT[4]=0.
REQ-031 SHALL be verified by: i_tx_ready=0, write 9 TX bytes -> tx_full=1, TX_OVF=1; raise i_tx_ready -> 8 bytes emitted in order, one per cycle.
REQ-032 SHALL be verified by: strobe with i_frame_err=1 -> no RX push, FERR=1; with err_ie=1 -> o_irq=1 next cycle.
REQ-033 SHALL be verified by: RX full, same-cycle RX strobe and RX_DATA read -> no OVR, LEVEL stays 8, data ordered.
REQ-034 SHALL be verified by: CTRL write 0x18 with both FIFOs non-empty -> LEVEL=0 next cycle, CTRL reads 0.
